// File: rtl/approx_fp_mul_pipe.sv
// Three-stage pipelined approximate floating-point multiplier with valid/ready flow control.
// Define APPROX_FLAGS_EN to add the registered flags_o port {invalid, overflow, underflow, inexact}.
module approx_fp_mul_pipe #(
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned MAN_W  = 7,
   parameter int unsigned PREC_W = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a_i,
   input  logic [EXP_W+MAN_W:0]   b_i,
   input  logic [PREC_W-1:0]      prec_i,
   output logic                   out_valid,
   input  logic                   out_ready,
`ifdef APPROX_FLAGS_EN
   output logic [3:0]             flags_o,
`endif
   output logic [EXP_W+MAN_W:0]   product_o
);

   localparam int unsigned W  = 1 + EXP_W + MAN_W;
   localparam int unsigned MW = MAN_W + 1;
   localparam int unsigned PW = 2 * MW;
   localparam int unsigned XW = EXP_W + 2;
   localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [XW-1:0] EXP_TOP  = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);

   // Flow control: each stage loads when empty or when its content moves on this cycle.
   logic r_v1, r_v2, r_v3;
   logic w_ld1, w_ld2, w_ld3;

   assign w_ld3     = !r_v3 || out_ready;
   assign w_ld2     = !r_v2 || w_ld3;
   assign w_ld1     = !r_v1 || w_ld2;
   assign in_ready  = w_ld1;
   assign out_valid = r_v3;

   // Stage 1: unpack, mask, classify, exponent sum
   logic [EXP_W-1:0]     w_ea, w_eb;
   logic [MAN_W-1:0]     w_fa, w_fb;
   logic [MW-1:0]        w_mask, w_ma, w_mb;
   logic                 w_za, w_zb, w_ia, w_ib, w_na, w_nb;
   logic                 w_nan, w_inf, w_zero;
   logic signed [XW-1:0] w_esum;

   always_comb begin
      w_ea = a_i[W-2 -: EXP_W];
      w_eb = b_i[W-2 -: EXP_W];
      w_fa = a_i[MAN_W-1:0];
      w_fb = b_i[MAN_W-1:0];
      if (32'(prec_i) > MAN_W) w_mask = {MW{1'b1}} << MAN_W;
      else                     w_mask = {MW{1'b1}} << prec_i;
      w_ma   = {1'b1, w_fa} & w_mask;
      w_mb   = {1'b1, w_fb} & w_mask;
      w_za   = (w_ea == '0);
      w_zb   = (w_eb == '0);
      w_ia   = (&w_ea) && (w_fa == '0);
      w_ib   = (&w_eb) && (w_fb == '0);
      w_na   = (&w_ea) && (w_fa != '0);
      w_nb   = (&w_eb) && (w_fb != '0);
      w_nan  = w_na || w_nb || ((w_ia || w_ib) && (w_za || w_zb));
      w_inf  = w_ia || w_ib;
      w_zero = w_za || w_zb;
      w_esum = $signed(XW'(w_ea)) + $signed(XW'(w_eb)) - BIAS;
   end

   logic                 r1_sign, r1_nan, r1_inf, r1_zero;
   logic signed [XW-1:0] r1_exp;
   logic [MW-1:0]        r1_ma, r1_mb;
   logic                 r2_sign, r2_nan, r2_inf, r2_zero;
   logic signed [XW-1:0] r2_exp;
   logic [PW-1:0]        r2_prod;
`ifdef APPROX_FLAGS_EN
   logic                 r1_lossy, r2_lossy;
`endif

   always_ff @(posedge clk) begin
      if (w_ld1 && in_valid) begin
         r1_sign <= a_i[W-1] ^ b_i[W-1];
         r1_exp  <= w_esum;
         r1_ma   <= w_ma;
         r1_mb   <= w_mb;
         r1_nan  <= w_nan;
         r1_inf  <= w_inf;
         r1_zero <= w_zero;
`ifdef APPROX_FLAGS_EN
         r1_lossy <= (|({1'b1, w_fa} & ~w_mask)) || (|({1'b1, w_fb} & ~w_mask));
`endif
      end
      if (w_ld2 && r_v1) begin
         r2_sign <= r1_sign;
         r2_exp  <= r1_exp;
         r2_prod <= PW'(r1_ma) * PW'(r1_mb);
         r2_nan  <= r1_nan;
         r2_inf  <= r1_inf;
         r2_zero <= r1_zero;
`ifdef APPROX_FLAGS_EN
         r2_lossy <= r1_lossy;
`endif
      end
   end

   // Stage 3: normalise by truncation, then resolve exceptions in priority order
   logic signed [XW-1:0] w_enorm;
   logic [MAN_W-1:0]     w_man;
   logic [W-1:0]         w_res;
   logic                 w_inv, w_ovf, w_unf;

   always_comb begin
      w_enorm = r2_exp;
      w_man   = r2_prod[PW-3 -: MAN_W];
      if (r2_prod[PW-1]) begin
         w_enorm = r2_exp + EXP_ONE;
         w_man   = r2_prod[PW-2 -: MAN_W];
      end
      w_inv = 1'b0;
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_res = {r2_sign, w_enorm[EXP_W-1:0], w_man};
      if (r2_nan) begin
         w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         w_inv = 1'b1;
      end else if (r2_inf) begin
         w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (r2_zero) begin
         w_res = {r2_sign, {(W-1){1'b0}}};
      end else if (w_enorm >= EXP_TOP) begin
         w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_ovf = 1'b1;
      end else if (w_enorm <= EXP_ZERO) begin
         w_res = {r2_sign, {(W-1){1'b0}}};
         w_unf = 1'b1;
      end
   end

`ifdef APPROX_FLAGS_EN
   logic w_disc, w_inex;
   logic [3:0] r_flags;

   always_comb begin
      w_disc = r2_prod[PW-1] ? (|r2_prod[MAN_W:0]) : (|r2_prod[MAN_W-1:0]);
      w_inex = !(r2_nan || r2_inf || r2_zero) && (w_disc || r2_lossy);
   end

   assign flags_o = r_flags;
`else
   // Bits below the kept mantissa only matter for the inexact flag.
   logic w_unused;
   assign w_unused = ^{r2_prod[MAN_W-1:0], w_inv, w_ovf, w_unf};
`endif

   logic [W-1:0] r_product;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_v3      <= 1'b0;
         r_product <= '0;
`ifdef APPROX_FLAGS_EN
         r_flags   <= '0;
`endif
      end else begin
         if (w_ld1) r_v1 <= in_valid;
         if (w_ld2) r_v2 <= r_v1;
         if (w_ld3) r_v3 <= r_v2;
         if (w_ld3 && r_v2) begin
            r_product <= w_res;
`ifdef APPROX_FLAGS_EN
            r_flags   <= {w_inv, w_ovf, w_unf, w_inex};
`endif
         end
      end
   end

   assign product_o = r_product;

endmodule

// File: tb/tb_approx_fp_mul_pipe.sv
// Directed and randomised bench for approx_fp_mul_pipe with BF16 defaults.
// Flag checks are compiled in when APPROX_FLAGS_EN is defined.
module tb_approx_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a_i, b_i, product_o;
   logic [2:0]  prec_i;
`ifdef APPROX_FLAGS_EN
   logic [3:0]  flags_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] got_q[$];

   always #5 clk = ~clk;

   approx_fp_mul_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_i       (a_i),
      .b_i       (b_i),
      .prec_i    (prec_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef APPROX_FLAGS_EN
      .flags_o   (flags_o),
`endif
      .product_o (product_o)
   );

   // Records every product transfer; inputs are only changed just after rising edges.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back(product_o);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] p);
      int ea, eb, e;
      int unsigned ma, mb, pr, m;
      logic s, za, zb, ia, ib, na, nb;
      s  = a[15] ^ b[15];
      ea = int'(a[14:7]);
      eb = int'(b[14:7]);
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 255) && (a[6:0] == 7'd0);
      ib = (eb == 255) && (b[6:0] == 7'd0);
      na = (ea == 255) && (a[6:0] != 7'd0);
      nb = (eb == 255) && (b[6:0] != 7'd0);
      if (na || nb || ((ia || ib) && (za || zb))) return 16'h7FC0;
      if (ia || ib) return {s, 15'h7F80};
      if (za || zb) return {s, 15'h0000};
      ma = (int'(a[6:0]) + 128) >> p << p;
      mb = (int'(b[6:0]) + 128) >> p << p;
      pr = ma * mb;
      e  = ea + eb - 127;
      if (pr >= 32768) begin
         e = e + 1;
         m = (pr / 256) % 128;
      end else begin
         m = (pr / 128) % 128;
      end
      if (e >= 255) return {s, 15'h7F80};
      if (e <= 0) return {s, 15'h0000};
      return {s, 8'(e), 7'(m)};
   endfunction

   // Single operation through an empty pipe; lat counts edges from the accept edge to out_valid.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] p,
                         output logic [15:0] prod, output logic [3:0] flg, output int lat);
      a_i = a;
      b_i = b;
      prec_i = p;
      in_valid = 1'b1;
      out_ready = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) in_valid = 1'b0;
      end while (!out_valid && lat < 20);
      prod = product_o;
`ifdef APPROX_FLAGS_EN
      flg = flags_o;
`else
      flg = 4'h0;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a_i = '0;
      b_i = '0;
      prec_i = '0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_checks++;
      if (product_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_product: got %h want 0000", product_o);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_exact;
      logic [15:0] a_v[2], b_v[2], e_v[2], prod;
      logic [3:0]  flg;
      int lat;
      a_v = '{16'h3FC0, 16'h3F80};
      b_v = '{16'h4000, 16'hBF80};
      e_v = '{16'h4040, 16'hBF80};
      for (int i = 0; i < 2; i++) begin
         run_op(a_v[i], b_v[i], 3'd0, prod, flg, lat);
         n_checks++;
         if (prod !== e_v[i]) begin
            n_fail++;
            $display("FAIL exact_%0d: got %h want %h", i, prod, e_v[i]);
         end
         n_checks++;
         if (lat !== 3) begin
            n_fail++;
            $display("FAIL latency_%0d: got %0d want 3", i, lat);
         end
      end
   endtask

   task automatic test_precision;
      logic [2:0]  p_v[3];
      logic [15:0] e_v[3], prod;
      logic [3:0]  f_v[3], flg;
      int lat;
      p_v = '{3'd4, 3'd0, 3'd7};
      e_v = '{16'h3FF0, 16'h3FFF, 16'h3F80};
      f_v = '{4'b0001, 4'b0000, 4'b0001};
      for (int i = 0; i < 3; i++) begin
         run_op(16'h3FFF, 16'h3F80, p_v[i], prod, flg, lat);
         n_checks++;
         if (prod !== e_v[i]) begin
            n_fail++;
            $display("FAIL prec_%0d: got %h want %h", p_v[i], prod, e_v[i]);
         end
`ifdef APPROX_FLAGS_EN
         n_checks++;
         if (flg !== f_v[i]) begin
            n_fail++;
            $display("FAIL prec_flags_%0d: got %b want %b", p_v[i], flg, f_v[i]);
         end
`endif
      end
   endtask

   task automatic test_exceptions;
      logic [15:0] a_v[4], b_v[4], e_v[4], prod;
      logic [3:0]  f_v[4], flg;
      int lat;
      a_v = '{16'h7F80, 16'h7F00, 16'h0080, 16'h0001};
      b_v = '{16'h0000, 16'h7F00, 16'h0080, 16'h4000};
      e_v = '{16'h7FC0, 16'h7F80, 16'h0000, 16'h0000};
      f_v = '{4'b1000, 4'b0100, 4'b0010, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         run_op(a_v[i], b_v[i], 3'd0, prod, flg, lat);
         n_checks++;
         if (prod !== e_v[i]) begin
            n_fail++;
            $display("FAIL except_%0d: got %h want %h", i, prod, e_v[i]);
         end
`ifdef APPROX_FLAGS_EN
         n_checks++;
         if (flg !== f_v[i]) begin
            n_fail++;
            $display("FAIL except_flags_%0d: got %b want %b", i, flg, f_v[i]);
         end
`endif
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] b_v[6], e_v[6];
      int k = 0, cyc = 0;
      logic rdy;
      b_v = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0};
      e_v = '{16'h4000, 16'h4080, 16'h40C0, 16'h4100, 16'h4120, 16'h4140};
      got_q.delete();
      out_ready = 1'b0;
      prec_i = 3'd0;
      a_i = 16'h4000;
      while (k < 6 && cyc < 20) begin
         b_i = b_v[k];
         in_valid = 1'b1;
         @(negedge clk);
         rdy = in_ready;
         if (!rdy) break;
         @(posedge clk);
         #1;
         cyc++;
         k++;
      end
      n_checks++;
      if (k !== 3) begin
         n_fail++;
         $display("FAIL stall_accepts: got %0d want 3", k);
      end
      @(posedge clk);
      #1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (product_o !== 16'h4000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_hold: got prod=%h ov=%b ir=%b want 4000/1/0",
                  product_o, out_valid, in_ready);
      end
      out_ready = 1'b1;
      cyc = 0;
      while (got_q.size() < 6 && cyc < 40) begin
         if (k < 6) begin
            b_i = b_v[k];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (in_valid && rdy) k++;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (got_q.size() !== 6) begin
         n_fail++;
         $display("FAIL bp_count: got %0d want 6", got_q.size());
      end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== e_v[i]) begin
            n_fail++;
            $display("FAIL bp_order_%0d: got %h want %h", i, got_q[i], e_v[i]);
         end
      end
   endtask

   task automatic test_random;
      logic [15:0] exp_q[$];
      logic [15:0] a, b;
      logic [2:0]  p;
      logic rdy;
      int acc = 0, cyc = 0, bad = 0;
      got_q.delete();
      a = 16'($urandom);
      b = 16'($urandom);
      p = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a[14:7] = 8'($urandom_range(100, 154));
      if ($urandom_range(0, 3) != 0) b[14:7] = 8'($urandom_range(100, 154));
      while ((acc < 1000 || got_q.size() < acc) && cyc < 20000) begin
         a_i = a;
         b_i = b;
         prec_i = p;
         in_valid = (acc < 1000);
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (in_valid && rdy) begin
            exp_q.push_back(model(a, b, p));
            acc++;
            a = 16'($urandom);
            b = 16'($urandom);
            p = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) a[14:7] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 3) != 0) b[14:7] = 8'($urandom_range(100, 154));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (got_q.size() !== 1000 || exp_q.size() !== 1000) begin
         n_fail++;
         $display("FAIL rand_count: got %0d outputs for %0d accepts want 1000",
                  got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            bad++;
            if (bad <= 10) $display("FAIL rand_%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_midstream;
      logic [15:0] prod;
      logic [3:0]  flg;
      int lat;
      out_ready = 1'b0;
      prec_i = 3'd0;
      a_i = 16'h3F80;
      b_i = 16'h4000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      b_i = 16'h4040;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_pre: got out_valid=%b want 1", out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || product_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL midreset_now: got ov=%b prod=%h want 0/0000", out_valid, product_o);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      got_q.delete();
      run_op(16'h4000, 16'h4000, 3'd0, prod, flg, lat);
      n_checks++;
      if (prod !== 16'h4080 || lat !== 3) begin
         n_fail++;
         $display("FAIL midreset_op: got %h lat %0d want 4080 lat 3", prod, lat);
      end
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (got_q.size() !== 1) begin
         n_fail++;
         $display("FAIL midreset_stale: got %0d outputs want 1", got_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_exact();
      test_precision();
      test_exceptions();
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
